// File: rtl/atm_arb_pkg.sv
// atm_arb_pkg: shared types for the ATM balance arbiter.
// State encoding, balance width and round-robin index helper.
package atm_arb_pkg;

    localparam int BAL_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        SERVE,
        WRITE,
        RELEASE
    } state_t;

    // Index reached k steps above p, wrapping at n.
    function automatic int rr_idx(input int p, input int k, input int n);
        int j;
        j = p + k;
        if (j >= n) j = j - n;
        return j;
    endfunction

endpackage

// File: rtl/atm_rr_picker.sv
// atm_rr_picker: combinational round-robin picker.
// First set request at or above ptr, wrapping, as one-hot and index.
module atm_rr_picker
    import atm_arb_pkg::*;
#(
    parameter int NUM_ATM = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_ATM-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_ATM-1:0] win_oh,
    output logic [IW-1:0]      win_idx,
    output logic               any
);

    // Scan upward from the pointer; the first hit wins.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        for (int k = 0; k < NUM_ATM; k++) begin
            if (!any && req[IW'(rr_idx(int'(ptr), k, NUM_ATM))]) begin
                any     = 1'b1;
                win_idx = IW'(rr_idx(int'(ptr), k, NUM_ATM));
                win_oh[IW'(rr_idx(int'(ptr), k, NUM_ATM))] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/atm_balance_arbiter.sv
// atm_balance_arbiter: round-robin locked read-modify-write of a balance store.
// Optional SERVE timeout enabled by defining ATM_ARB_TIMEOUT_EN.
module atm_balance_arbiter
    import atm_arb_pkg::*;
#(
    parameter int NUM_ATM        = 4,
    parameter int ACCT_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_ATM-1:0]        req,
    input  logic [NUM_ATM*ACCT_W-1:0] cuenta_id,
    input  logic [NUM_ATM-1:0]        balance_stb,
    input  logic [NUM_ATM*64-1:0]     balance_actualizado,
    input  logic [NUM_ATM-1:0]        done,
    output logic [NUM_ATM-1:0]        grant,
    output logic [63:0]               balance_inicial,
    output logic [NUM_ATM-1:0]        balance_valid,
    output logic [ACCT_W-1:0]         mem_addr,
    output logic                      mem_rd_en,
    input  logic [63:0]               mem_rdata,
    output logic                      mem_wr_en,
    output logic [63:0]               mem_wdata,
    output logic                      timeout
);

    localparam int IW = (NUM_ATM > 1) ? $clog2(NUM_ATM) : 1;

    state_t             state_q;
    state_t             state_d;
    logic [IW-1:0]      ptr_q;
    logic [IW-1:0]      win_q;
    logic [NUM_ATM-1:0] win_oh_q;
    logic [ACCT_W-1:0]  acct_q;
    logic [BAL_W-1:0]   bal_q;
    logic [BAL_W-1:0]   wdat_q;
    logic               to_q;

    logic               pk_any;
    logic [NUM_ATM-1:0] pk_oh;
    logic [IW-1:0]      pk_idx;
    logic [ACCT_W-1:0]  pk_acct;
    logic [BAL_W-1:0]   upd_w;
    logic               req_w;
    logic               stb_w;
    logic               done_w;
    logic               to_hit;
    logic               rel_to;

    atm_rr_picker #(
        .NUM_ATM (NUM_ATM),
        .IW      (IW)
    ) u_picker (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (pk_oh),
        .win_idx (pk_idx),
        .any     (pk_any)
    );

    // Slice out the picked account and the granted ATM's new balance.
    always_comb begin
        pk_acct = '0;
        upd_w   = '0;
        for (int i = 0; i < NUM_ATM; i++) begin
            if (pk_idx == IW'(i))
                pk_acct = cuenta_id[i*ACCT_W +: ACCT_W];
            if (win_q == IW'(i))
                upd_w = balance_actualizado[i*BAL_W +: BAL_W];
        end
    end

    assign req_w  = |(req & win_oh_q);
    assign stb_w  = |(balance_stb & win_oh_q);
    assign done_w = |(done & win_oh_q);

`ifdef ATM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // Count SERVE cycles; cleared whenever the arbiter is elsewhere.
    always_ff @(posedge clk) begin
        if (reset || state_q != SERVE)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign to_hit = (state_q == SERVE) &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // No timer: never fires, SERVE waits for the controller.
    assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

    // Next-state selection; strobe beats done, done beats timeout.
    always_comb begin
        state_d = state_q;
        rel_to  = 1'b0;
        unique case (state_q)
            IDLE:    if (pk_any) state_d = READ;
            READ:    state_d = CAPTURE;
            CAPTURE: state_d = SERVE;
            SERVE: begin
                if (stb_w) begin
                    state_d = WRITE;
                end else if (done_w || !req_w) begin
                    state_d = RELEASE;
                end else if (to_hit) begin
                    state_d = RELEASE;
                    rel_to  = 1'b1;
                end
            end
            WRITE:   state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the current state and latched transaction.
    always_comb begin
        grant           = '0;
        balance_valid   = '0;
        balance_inicial = '0;
        mem_addr        = '0;
        mem_rd_en       = 1'b0;
        mem_wr_en       = 1'b0;
        mem_wdata       = '0;
        timeout         = 1'b0;
        unique case (state_q)
            READ: begin
                grant     = win_oh_q;
                mem_rd_en = 1'b1;
                mem_addr  = acct_q;
            end
            CAPTURE: begin
                grant = win_oh_q;
            end
            SERVE: begin
                grant           = win_oh_q;
                balance_valid   = win_oh_q;
                balance_inicial = bal_q;
            end
            WRITE: begin
                grant           = win_oh_q;
                balance_inicial = bal_q;
                mem_wr_en       = 1'b1;
                mem_addr        = acct_q;
                mem_wdata       = wdat_q;
            end
            RELEASE: begin
                timeout = to_q;
            end
            default: begin
            end
        endcase
    end

    // Transaction registers and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            win_oh_q <= '0;
            acct_q   <= '0;
            bal_q    <= '0;
            wdat_q   <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            to_q    <= rel_to;
            if (state_q == IDLE && pk_any) begin
                win_q    <= pk_idx;
                win_oh_q <= pk_oh;
                acct_q   <= pk_acct;
            end
            if (state_q == CAPTURE)
                bal_q <= mem_rdata;
            if (state_q == SERVE && stb_w)
                wdat_q <= upd_w;
            if (state_q == RELEASE) begin
                if (win_q == IW'(NUM_ATM - 1))
                    ptr_q <= '0;
                else
                    ptr_q <= win_q + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_atm_balance_arbiter.sv
// tb_atm_balance_arbiter: vector table, hand sequences and random
// transactions checked against a bank/pointer model.
module tb_atm_balance_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int AW = 8;
    localparam int BW = 64;
    localparam int TO = 16;

    localparam int A_STB  = 0;
    localparam int A_DONE = 1;
    localparam int A_BOTH = 2;
    localparam int A_DROP = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*AW-1:0] cuenta_id;
    logic [N-1:0]    balance_stb;
    logic [N*BW-1:0] balance_actualizado;
    logic [N-1:0]    done;
    logic [N-1:0]    grant;
    logic [63:0]     balance_inicial;
    logic [N-1:0]    balance_valid;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd_en;
    logic [63:0]     mem_rdata;
    logic            mem_wr_en;
    logic [63:0]     mem_wdata;
    logic            timeout;

    always #5 clk = ~clk;

    atm_balance_arbiter #(
        .NUM_ATM        (N),
        .ACCT_W         (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .req                 (req),
        .cuenta_id           (cuenta_id),
        .balance_stb         (balance_stb),
        .balance_actualizado (balance_actualizado),
        .done                (done),
        .grant               (grant),
        .balance_inicial     (balance_inicial),
        .balance_valid       (balance_valid),
        .mem_addr            (mem_addr),
        .mem_rd_en           (mem_rd_en),
        .mem_rdata           (mem_rdata),
        .mem_wr_en           (mem_wr_en),
        .mem_wdata           (mem_wdata),
        .timeout             (timeout)
    );

    logic [63:0] mem     [256];
    logic [63:0] ref_mem [256];
    int          wr_count = 0;

    // Bank store: one-cycle read latency, write on strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wdata;
            wr_count++;
        end
    end

    int checks   = 0;
    int failures = 0;
    int ptr_m    = 0;

    typedef struct {
        logic [N-1:0] rq;
        logic [7:0]   acct;
        int           act;
        logic [63:0]  nv;
        int           exp_w;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[IW'((p + k) % N)]) return (p + k) % N;
        return -1;
    endfunction

    task automatic set_accts(input int w, input logic [7:0] acct);
        for (int i = 0; i < N; i++)
            cuenta_id[i*AW +: AW] = (i == w) ? acct : acct + 8'(i + 1);
    endtask

    task automatic run_txn(input logic [N-1:0] rmask, input logic [7:0] acct,
                           input int act, input logic [63:0] nv,
                           input int w, input int wait_n);
        logic [N-1:0] oh;
        oh  = N'(1) << w;
        req = rmask;
        set_accts(w, acct);
        tick();
        chk("rd_grant", grant, oh);
        chk("rd_en", mem_rd_en, 1);
        chk("rd_addr", mem_addr, acct);
        chk("rd_no_wr", mem_wr_en, 0);
        cuenta_id = ~cuenta_id;
        tick();
        chk("cap_grant", grant, oh);
        chk("cap_valid", balance_valid, 0);
        tick();
        chk("srv_grant", grant, oh);
        chk("srv_valid", balance_valid, oh);
        chk("srv_bal", balance_inicial, ref_mem[acct]);
        balance_stb = ~oh;
        done        = ~oh;
        for (int i = 0; i < N; i++)
            balance_actualizado[i*BW +: BW] = {$urandom, $urandom};
        tick();
        balance_stb = '0;
        done        = '0;
        chk("foreign_valid", balance_valid, oh);
        chk("foreign_no_wr", mem_wr_en, 0);
        repeat (wait_n) tick();
        case (act)
            A_STB: begin
                balance_stb = oh;
                balance_actualizado[w*BW +: BW] = nv;
            end
            A_DONE: done = oh;
            A_BOTH: begin
                balance_stb = oh;
                done        = oh;
                balance_actualizado[w*BW +: BW] = nv;
            end
            default: req = rmask & ~oh;
        endcase
        tick();
        balance_stb = '0;
        done        = '0;
        if (act == A_STB || act == A_BOTH) begin
            chk("wr_en", mem_wr_en, 1);
            chk("wr_addr", mem_addr, acct);
            chk("wr_data", mem_wdata, nv);
            chk("wr_grant", grant, oh);
            ref_mem[acct] = nv;
            tick();
        end else begin
            chk("rel_no_wr", mem_wr_en, 0);
        end
        chk("rel_grant", grant, 0);
        chk("rel_valid", balance_valid, 0);
        chk("rel_bal", balance_inicial, 0);
        chk("rel_addr", mem_addr, 0);
        chk("rel_timeout", timeout, 0);
        req = '0;
        tick();
        chk("mem_after", mem[acct], ref_mem[acct]);
        ptr_m = (w + 1) % N;
    endtask

    initial begin
        int wc;
        int serve_n;
        logic to_seen;
        logic [N-1:0] rm;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 64'(1000 + i * 7);
            ref_mem[i] = 64'(1000 + i * 7);
        end
        mem[5]     = 64'd100;
        ref_mem[5] = 64'd100;

        tbl[0] = '{4'b0011, 8'd10, A_STB,  64'd111,  0};
        tbl[1] = '{4'b0010, 8'd11, A_DONE, 64'd0,    1};
        tbl[2] = '{4'b1001, 8'd12, A_STB,  64'd222,  3};
        tbl[3] = '{4'b1001, 8'd13, A_BOTH, 64'd333,  0};
        tbl[4] = '{4'b0100, 8'd5,  A_STB,  64'd75,   2};
        tbl[5] = '{4'b0010, 8'd20, A_DROP, 64'd0,    1};
        tbl[6] = '{4'b1111, 8'd21, A_STB,  64'hABCD, 2};
        tbl[7] = '{4'b0111, 8'd22, A_DONE, 64'd0,    0};

        reset               = 1'b1;
        req                 = '0;
        cuenta_id           = '0;
        balance_stb         = '0;
        balance_actualizado = '0;
        done                = '0;
        tick();
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_valid", balance_valid, 0);
        chk("rst_bal", balance_inicial, 0);
        chk("rst_rd", mem_rd_en, 0);
        chk("rst_wr", mem_wr_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_timeout", timeout, 0);
        reset = 1'b0;
        ptr_m = 0;

        for (int t = 0; t < 8; t++)
            run_txn(tbl[t].rq, tbl[t].acct, tbl[t].act, tbl[t].nv,
                    tbl[t].exp_w, t % 3);
        chk("acct5_final", mem[5], 64'd75);

        // Reset while serving ATM1, with its strobe in the same cycle.
        wc  = wr_count;
        req = 4'b0010;
        set_accts(1, 8'd30);
        tick();
        tick();
        tick();
        chk("mid_valid", balance_valid, 4'b0010);
        balance_stb = 4'b0010;
        balance_actualizado[1*BW +: BW] = 64'hDEAD;
        reset = 1'b1;
        tick();
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_valid", balance_valid, 0);
        chk("mid_rst_bal", balance_inicial, 0);
        chk("mid_rst_wr", mem_wr_en, 0);
        reset       = 1'b0;
        balance_stb = '0;
        req         = '0;
        tick();
        tick();
        chk("mid_no_write", wr_count, wc);
        chk("mid_mem", mem[30], ref_mem[30]);
        ptr_m = 0;
        run_txn(4'b1111, 8'd31, A_STB, 64'd4444, 0, 0);

        // Controller that never answers.
        wc  = wr_count;
        rm  = 4'b0100;
        req = rm;
        set_accts(2, 8'd40);
        tick();
        tick();
        tick();
        chk("to_valid", balance_valid, rm);
        serve_n = 1;
        to_seen = 1'b0;
`ifdef ATM_ARB_TIMEOUT_EN
        for (int c = 0; c < 40; c++) begin
            tick();
            if (balance_valid == '0) break;
            serve_n++;
        end
        chk("to_serve_len", serve_n, TO);
        chk("to_pulse", timeout, 1);
        chk("to_grant", grant, 0);
        req = '0;
        tick();
        chk("to_pulse_end", timeout, 0);
`else
        for (int c = 0; c < 20; c++) begin
            tick();
            to_seen = to_seen | timeout;
        end
        chk("noto_still_valid", balance_valid, rm);
        chk("noto_timeout", to_seen, 0);
        done = rm;
        tick();
        done = '0;
        chk("noto_rel_grant", grant, 0);
        req = '0;
        tick();
`endif
        chk("to_no_write", wr_count, wc);
        ptr_m = 3;

        for (int r = 0; r < 30; r++) begin
            logic [N-1:0] rmask;
            rmask = N'($urandom_range(1, 15));
            run_txn(rmask, 8'($urandom_range(0, 255)),
                    $urandom_range(0, 3), {$urandom, $urandom},
                    model_pick(rmask, ptr_m), $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/atm_balance_arbiter.md
Name: atm_balance_arbiter

Overview:
Shares one single-port account-balance store between NUM_ATM ATM transaction controllers. Grants are round-robin, and each grant runs a locked read-modify-write sequence:
- read the requester's account balance and deliver it as balance_inicial;
- wait for the controller's updated balance (balance_stb / balance_actualizado);
- write that value back, or release without writing.

The block sits between the ATM controllers and the bank balance memory.

Parameters:
NUM_ATM, 4, number of requesting ATM controllers (2..8)
ACCT_W, 8, account index width
TIMEOUT_CYCLES, 64, SERVE-state cycle limit (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  NUM_ATM  per-ATM access request; level, held for the whole transaction
cuenta_id  in  NUM_ATM*ACCT_W  per-ATM account index; slice i belongs to ATM i
balance_stb  in  NUM_ATM  per-ATM one-cycle strobe: write back balance_actualizado
balance_actualizado  in  NUM_ATM*64  per-ATM updated balance
done  in  NUM_ATM  per-ATM one-cycle strobe: release without write
grant  out  NUM_ATM  one-hot grant, or all-zero
balance_inicial  out  64  balance read for the granted ATM
balance_valid  out  NUM_ATM  one-hot; marks balance_inicial valid for that ATM
mem_addr  out  ACCT_W  store address
mem_rd_en  out  1  read strobe; mem_rdata is valid the following cycle
mem_rdata  in  64  store read data
mem_wr_en  out  1  write strobe
mem_wdata  out  64  store write data
timeout  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset: all outputs 0, round-robin pointer = 0, state IDLE. Reset mid-transaction abandons it; no write occurs.
- State machine: IDLE -> READ -> CAPTURE -> SERVE -> (WRITE) -> RELEASE -> IDLE.
- IDLE:
  - If any req bit is set, the winner w is the first set bit searching upward from the pointer, wrapping at NUM_ATM.
  - The account index cuenta_id[w] is latched.
  - Next state READ.
- READ (1 cycle): grant[w]=1, mem_rd_en=1, mem_addr = latched account.
- CAPTURE (1 cycle): mem_rdata is registered into balance_inicial.
- SERVE:
  - balance_valid[w]=1 and grant[w]=1 throughout.
  - Latency: req seen at cycle t -> grant and mem_rd_en at t+1 -> balance_valid at t+3.
  - balance_stb[w] -> latch balance_actualizado slice w, go to WRITE.
  - done[w] -> RELEASE with no write.
  - req[w] deasserted -> RELEASE with no write.
  - balance_stb[w] and done[w] in the same cycle -> balance_stb wins.
  - Strobes from non-granted ATMs are ignored.
- WRITE (1 cycle): mem_wr_en=1, mem_addr = latched account, mem_wdata = latched value.
- RELEASE (1 cycle):
  - grant, balance_valid and balance_inicial are all 0.
  - Pointer = (w+1) mod NUM_ATM.
  - Next state IDLE.
  - Minimum back-to-back turnaround: 6 cycles.
- mem_rd_en and mem_wr_en are never asserted together. mem_addr is 0 outside READ and WRITE.
- No arithmetic on the balance; the arbiter passes values through unchanged. The controller is responsible for insufficient-funds checks.
- Changes to cuenta_id after IDLE are ignored.

Optional Feature:
ATM_ARB_TIMEOUT_EN
- Defined:
  - A SERVE cycle counter starts at 0 on SERVE entry.
  - If it reaches TIMEOUT_CYCLES with no strobe, the arbiter goes to RELEASE with no write.
  - timeout pulses 1 for one cycle, coincident with RELEASE.
- Undefined: no counter exists; timeout is tied to 0; SERVE waits indefinitely.

Decomposition:
- Package atm_arb_pkg: state enum (IDLE, READ, CAPTURE, SERVE, WRITE, RELEASE) and constant BAL_W=64.
- One sub-module, atm_rr_picker: combinational round-robin picker (req and pointer in; one-hot winner and index out).

Test Plan:
- Single-ATM withdrawal: acct 5 holds 100; req[2]=1 with cuenta_id=5 -> grant=0100 at t+1 and balance_inicial=100 at t+3. balance_stb[2] with value 75 -> mem_wr_en, addr 5, wdata 75; grant drops the next cycle.
- Contention after reset: req=0011 -> ATM0 served first, then ATM1. With req=1001 pending and pointer=2 -> ATM3 is served before ATM0.
- Release without write: done[1] in SERVE -> no mem_wr_en, acct unchanged, grant=0. A simultaneous balance_stb[1]+done[1] -> write occurs.
- Reset mid-SERVE: reset=1 -> all outputs 0 next cycle, no write, pointer=0.
- Foreign strobe: balance_stb[3] while ATM1 is granted -> ignored, no write.
- With ATM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: no strobe -> release after 16 SERVE cycles, timeout=1 for 1 cycle, no write. Without the macro, timeout stays 0.
